// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and sizing helpers shared by the bit-serial blocks
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// serial_fa_bit: 1-bit full adder {co,s} = a + b + ci
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_fsm.sv
// serial_addsub_fsm: LSB-first bit-serial add/subtract with start/busy/done handshake
module serial_addsub_fsm
    import serial_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit REG_OUT = 1
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             clr,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             s_bit,
    output logic             s_valid,
    output logic             s_cout
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c, run, last;

    serial_fa_bit u_fa (
        .a (op_a[0]),
        .b (op_b[0]),
        .ci(carry),
        .s (fa_s),
        .co(fa_c)
    );

    assign run  = state == RUN;
    assign last = run && cnt == CW'(WIDTH - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        state_nx = clr ? IDLE :
                   (state == IDLE) ? (start ? RUN : IDLE) :
                   run ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) state <= IDLE;
        else       state <= state_nx;
    end

    // result bits fill op_a from the MSB as its operand bits drain out the LSB
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (run) begin
            op_a  <= {fa_s, op_a[WIDTH-1:1]};
            op_b  <= op_b >> 1;
            carry <= fa_c;
            cnt   <= last ? cnt : cnt + CW'(1);
            if (last) begin
                sum  <= {fa_s, op_a[WIDTH-1:1]};
                cout <= fa_c;
                ovf  <= carry ^ fa_c;
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge CLK or negedge NRST) begin
                if (!NRST) begin
                    s_bit   <= 1'b0;
                    s_valid <= 1'b0;
                    s_cout  <= 1'b0;
                end else begin
                    s_bit   <= run & fa_s;
                    s_valid <= run;
                    s_cout  <= run & fa_c;
                end
            end
        end else begin : g_comb
            assign s_bit   = run & fa_s;
            assign s_valid = run;
            assign s_cout  = run & fa_c;
        end
    endgenerate

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// tb_serial_addsub_fsm: directed checks of the serial add/sub controller in three configurations
module tb_serial_addsub_fsm;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        clr = 1'b0;
    logic        start8 = 1'b0, sub8 = 1'b0, start16 = 1'b0, sub16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic        busy0, done0, cout0, ovf0, sb0, sv0, sc0;
    logic        busy1, done1, cout1, ovf1, sb1, sv1, sc1;
    logic        busy2, done2, cout2, ovf2, sb2, sv2, sc2;
    logic [7:0]  sum0, sum1;
    logic [15:0] sum2;

    int          checks = 0, errors = 0;
    int          cyc, nv0, nv1, f0, f1, lat, cnt;
    logic [7:0]  st0, st1;

    always #5 CLK = ~CLK;

    serial_addsub_fsm #(.WIDTH(8), .REG_OUT(0)) u0 (
        .CLK(CLK), .NRST(NRST), .clr(clr), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0),
        .s_bit(sb0), .s_valid(sv0), .s_cout(sc0)
    );

    serial_addsub_fsm #(.WIDTH(8), .REG_OUT(1)) u1 (
        .CLK(CLK), .NRST(NRST), .clr(clr), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
        .s_bit(sb1), .s_valid(sv1), .s_cout(sc1)
    );

    serial_addsub_fsm #(.WIDTH(16), .REG_OUT(0)) u2 (
        .CLK(CLK), .NRST(NRST), .clr(clr), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2),
        .s_bit(sb2), .s_valid(sv2), .s_cout(sc2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
        cyc++;
        if (sv0) begin
            st0 = {sb0, st0[7:1]};
            nv0++;
            if (f0 < 0) f0 = cyc;
        end
        if (sv1) begin
            st1 = {sb1, st1[7:1]};
            nv1++;
            if (f1 < 0) f1 = cyc;
        end
    endtask

    task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic s, input int inj, output int n);
        a8 = aa; b8 = bb; sub8 = s; start8 = 1'b1;
        cyc = 0; nv0 = 0; nv1 = 0; f0 = -1; f1 = -1; st0 = '0; st1 = '0;
        tick;
        start8 = 1'b0;
        while (!done0 && cyc < 30) begin
            start8 = (cyc == inj);
            if (start8) begin
                a8 = ~aa; sub8 = ~s;
            end
            tick;
        end
        start8 = 1'b0;
        n = cyc;
    endtask

    task automatic res8(input string tag, input logic [7:0] es, input logic ec, input logic eo, input int n);
        chk({tag, "_lat"}, 64'(n), 64'd9);
        chk({tag, "_sum"}, 64'(sum0), 64'(es));
        chk({tag, "_cout"}, 64'(cout0), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf0), 64'(eo));
        chk({tag, "_r1"}, 64'({sum1, cout1, ovf1, done1, sv1, sv0}), 64'({es, ec, eo, 3'b110}));
    endtask

    task automatic op16(input logic [15:0] aa, input logic [15:0] bb, input logic s);
        logic [15:0] bx;
        logic [16:0] full;
        int          n;
        bx   = s ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, bx} + 17'(s);
        a16 = aa; b16 = bb; sub16 = s; start16 = 1'b1;
        tick;
        start16 = 1'b0;
        n = 1;
        while (!done2 && n < 40) begin
            tick;
            n++;
        end
        chk("w16_lat", 64'(n), 64'd17);
        chk("w16_sum", 64'(sum2), 64'(full[15:0]));
        chk("w16_cout", 64'(cout2), 64'(full[16]));
        chk("w16_ovf", 64'(ovf2), 64'((aa[15] == bx[15]) && (full[15] != aa[15])));
        tick;
    endtask

    initial begin
        #3;
        chk("rst0", 64'({busy0, done0, cout0, ovf0, sb0, sv0, sc0, sum0}), 64'd0);
        chk("rst1", 64'({busy1, done1, cout1, ovf1, sb1, sv1, sc1, sum1}), 64'd0);
        chk("rst2", 64'({busy2, done2, cout2, ovf2, sb2, sv2, sc2, sum2}), 64'd0);
        @(negedge CLK);
        NRST = 1'b1;
        tick;

        op8(8'h5A, 8'h3C, 1'b0, 0, lat);
        res8("add", 8'h96, 1'b0, 1'b1, lat);
        chk("add_stream0", 64'({st0, 4'(nv0), 4'(f0)}), 64'({8'h96, 4'd8, 4'd1}));
        chk("add_stream1", 64'({st1, 4'(nv1), 4'(f1)}), 64'({8'h96, 4'd8, 4'd2}));
        tick;
        chk("add_hold", 64'({busy0, done0, sum0}), 64'({2'b00, 8'h96}));

        op8(8'h10, 8'h20, 1'b1, 0, lat);
        res8("sub1", 8'hF0, 1'b0, 1'b0, lat);
        tick;
        op8(8'h80, 8'h01, 1'b1, 0, lat);
        res8("sub2", 8'h7F, 1'b1, 1'b1, lat);
        tick;
        op8(8'hFF, 8'h01, 1'b0, 0, lat);
        res8("wrap", 8'h00, 1'b1, 1'b0, lat);
        tick;
        op8(8'h5A, 8'h3C, 1'b0, 0, lat);
        res8("b2b", 8'h96, 1'b0, 1'b1, lat);
        tick;

        op8(8'h10, 8'h20, 1'b1, 3, lat);
        res8("ignore", 8'hF0, 1'b0, 1'b0, lat);
        tick;

        a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        tick;
        chk("abort_busy", 64'(busy0), 64'd1);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("abort_clr", 64'({busy0, done0, cout0, ovf0, busy1, sum1, sum0}), 64'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done0 || busy0) cnt++;
        end
        chk("abort_nodone", 64'(cnt), 64'd0);

        clr = 1'b1; start8 = 1'b1;
        tick;
        clr = 1'b0; start8 = 1'b0;
        chk("clr_start", 64'({busy0, busy1}), 64'd0);
        tick;
        chk("clr_start2", 64'({busy0, busy1}), 64'd0);

        op8(8'h5A, 8'h3C, 1'b0, 0, lat);
        res8("pre_rst", 8'h96, 1'b0, 1'b1, lat);
        tick;
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        chk("mid_run", 64'({busy0, sv0, busy1, sv1}), 64'hF);
        #1 NRST = 1'b0;
        #1;
        chk("arst0", 64'({busy0, done0, cout0, ovf0, sb0, sv0, sc0, sum0}), 64'd0);
        chk("arst1", 64'({busy1, done1, cout1, ovf1, sb1, sv1, sc1, sum1}), 64'd0);
        @(negedge CLK);
        NRST = 1'b1;
        tick;
        chk("arst_idle", 64'({busy0, busy1}), 64'd0);

        op16(16'h7FFF, 16'h0001, 1'b0);
        op16(16'h8000, 16'h0001, 1'b1);
        op16(16'h1234, 16'h1234, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 200; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub_fsm.md
Name: serial_addsub_fsm

Overview:
- Parametrised bit-serial adder/subtractor controller: LSB-first, one bit per clock, over WIDTH-bit operands.
- Successor to the fixed 1-bit sum/carry sequencer, adding:
  - configurable width;
  - add/subtract mode;
  - signed-overflow flag;
  - start/busy/done handshake;
  - a serial bit stream, optionally registered.
- Sits between a control sequencer issuing start/clr and a datapath consuming either the parallel result or the serial stream.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- REG_OUT, 1, 1 = serial outputs (s_bit, s_valid, s_cout) pass through one output register stage; 0 = combinational from the current-bit adder.

Ports:
- CLK  in  1  system clock, rising edge.
- NRST  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; priority over start.
- start  in  1  begin operation; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  parallel result; held until next done or clr.
- cout  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  signed overflow of the completed operation.
- s_bit  out  1  serial result bit, LSB first.
- s_valid  out  1  qualifies s_bit.
- s_cout  out  1  running carry after the current bit.

Behaviour:
- Reset: asynchronous, active-low NRST; CLK is the only clock. While NRST=0: state=IDLE, and all shift registers, counter, carry, sum, cout, ovf, done, busy, s_bit, s_valid, s_cout are 0.
- States: IDLE, RUN, DONE. State register clocked; next state and current-bit logic combinational.
- IDLE -> RUN on start=1 and clr=0. Same edge:
  - opA <= a;
  - opB <= sub ? ~b : b;
  - carry <= sub;
  - cnt <= 0.
- RUN, each cycle:
  - {c_next, bit} = opA[0] + opB[0] + carry;
  - opA and opB shift right by 1;
  - bit shifts into the result register from the MSB side;
  - carry <= c_next;
  - cnt <= cnt+1.
  - When cnt == WIDTH-1: capture c_in_msb = the carry entering the bit, and go to DONE.
- DONE, one cycle:
  - done=1;
  - sum = result register;
  - cout = final carry;
  - ovf = c_in_msb ^ cout.
  - Next state IDLE unconditionally.
- Latency: start sampled at edge t -> done high in cycle t+WIDTH+1; back-to-back restart is possible from the cycle after done. Throughput is one operation per WIDTH+2 cycles.
- start while busy: ignored, no queueing. sub, a and b are don't-care outside the start cycle.
- clr=1 in any state: next state IDLE; sum, cout, ovf, carry and cnt cleared; no done pulse. clr together with start in IDLE: clr wins, no operation starts.
- sum, cout and ovf update only at the RUN -> DONE edge and otherwise hold.
- Serial outputs:
  - REG_OUT=0: s_valid=1 during each RUN cycle; s_bit and s_cout reflect the current bit.
  - REG_OUT=1: the same signals delayed by exactly one clock. s_valid's last high cycle then coincides with done.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1.
- Asynchronous reset mid-RUN: immediate IDLE, all outputs 0; the operation is lost.

Decomposition:
- Shared package serial_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 illegal, decodes to IDLE);
  - localparam function for counter width.
- One natural sub-module, serial_fa_bit: 1-bit full adder {co,s} = a+b+ci, combinational, reused by future serial blocks.
- Output register stage stays inline under a REG_OUT generate.

Test Plan:
- Add, WIDTH=8, REG_OUT=0: a=0x5A, b=0x3C, sub=0, start for 1 cycle -> done exactly 9 cycles after the start edge; sum=0x96, cout=0, ovf=1. s_bit stream LSB-first 0,1,1,0,1,0,0,1.
- Subtract: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Wrap: a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Back-to-back start in the cycle after done is accepted; second done arrives 9 cycles later.
- Abort and ignore:
  - clr asserted on the 3rd RUN cycle -> IDLE next cycle, busy=0, no done, sum=0, cout=0.
  - start pulsed mid-RUN -> ignored; result equals the original operands.
- Reset and REG_OUT=1:
  - NRST low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
  - REG_OUT=1 repeat of the first test -> s_bit/s_valid shifted one cycle later; last s_valid coincides with done; sum unchanged.
- WIDTH=16 sweep of 200 random a/b/sub -> sum, cout and ovf match the 16-bit reference model; done at start+17.
